// File: rtl/eth_frame_gen_pkg.sv
// eth_frame_gen_pkg: shared constants, FSM states and keep helper for the TX frame generator.
package eth_frame_gen_pkg;
    localparam int ETH_HDR_LEN = 14;
    localparam int BEAT_BYTES = 8;
    localparam int KEEP_W = 8;
    typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;
    function automatic logic [KEEP_W-1:0] len_to_last_keep(input logic [15:0] len);
        return len[2:0] == 3'd0 ? '1 : (KEEP_W'(1) << len[2:0]) - KEEP_W'(1);
    endfunction
endpackage

// File: rtl/eth_mac_tx_frame_gen_if.sv
// eth_mac_tx_frame_gen_if: 64-bit AXI-stream TX bundle between frame source and MAC.
interface eth_mac_tx_frame_gen_if;
    logic [63:0] tdata;
    logic [7:0] tkeep;
    logic tlast;
    logic tuser;
    logic tvalid;
    logic tready;
    modport master(output tdata, tkeep, tlast, tuser, tvalid, input tready);
    modport slave(input tdata, tkeep, tlast, tuser, tvalid, output tready);
endinterface

// File: rtl/eth_frame_gen_beat.sv
// eth_frame_gen_beat: combinational assembler of one 8-byte beat from latched header and pattern seed.
module eth_frame_gen_beat
    import eth_frame_gen_pkg::*;
(
    input  logic [7:0]        beat_idx,
    input  logic              last,
    input  logic [KEEP_W-1:0] last_keep,
    input  logic [47:0]       dst_mac,
    input  logic [47:0]       src_mac,
    input  logic [15:0]       ethertype,
    input  logic [7:0]        seed,
    output logic [63:0]       tdata,
    output logic [KEEP_W-1:0] tkeep
);
    for (genvar n = 0; n < BEAT_BYTES; n++) begin : g_byte
        logic [15:0] p;
        assign p = {5'd0, beat_idx, 3'(n)};
        // wire byte p: header bytes MSB-first, then payload counting up from the seed
        assign tdata[8*n +: 8] = p < 16'd6  ? 8'(dst_mac >> (16'd40 - 16'd8 * p)) :
                                 p < 16'd12 ? 8'(src_mac >> (16'd88 - 16'd8 * p)) :
                                 p == 16'd12 ? ethertype[15:8] :
                                 p == 16'd13 ? ethertype[7:0] :
                                 seed + 8'(p - 16'(ETH_HDR_LEN));
    end
    assign tkeep = last ? last_keep : '1;
endmodule

// File: rtl/eth_mac_tx_frame_gen.sv
// eth_mac_tx_frame_gen: builds one padded/clamped Ethernet frame per start onto AXI-stream TX.
// Define ETH_FRAME_GEN_PTP_TS_EN to enable TX PTP timestamp capture onto ts_out.
module eth_mac_tx_frame_gen
    import eth_frame_gen_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514,
    parameter int TS_W = 96
) (
    input  logic                   tx_clk,
    input  logic                   tx_rst,
    input  logic                   start,
    input  logic [15:0]            frame_len,
    input  logic [47:0]            dst_mac,
    input  logic [47:0]            src_mac,
    input  logic [15:0]            ethertype,
    input  logic                   err_inject,
    output logic                   busy,
    eth_mac_tx_frame_gen_if.master tx_axis,
    input  logic [TS_W-1:0]        tx_ptp_ts,
    input  logic                   tx_ptp_ts_valid,
    output logic [TS_W-1:0]        ts_out,
    output logic                   ts_out_valid,
    output logic [31:0]            frame_count
);
    state_t state_q, state_d;
    logic [7:0] beat_q, beat_d, last_q, last_d, seed_q, seed_d;
    logic [KEEP_W-1:0] keep_q, keep_d;
    logic [47:0] dst_q, dst_d, src_q, src_d;
    logic [15:0] type_q, type_d;
    logic err_q, err_d;
    logic [31:0] count_q, count_d;
    logic [15:0] len_c;
    logic valid, last_beat, hs;
    logic [63:0] beat_data;
    logic [KEEP_W-1:0] beat_keep;

    assign len_c = frame_len < 16'(MIN_LEN) ? 16'(MIN_LEN) :
                   frame_len > 16'(MAX_LEN) ? 16'(MAX_LEN) : frame_len;
    assign valid = state_q != IDLE;
    assign last_beat = valid && beat_q == last_q;
    assign hs = valid && tx_axis.tready;

    always_comb begin
        state_d = state_q;
        beat_d = beat_q;
        last_d = last_q;
        keep_d = keep_q;
        dst_d = dst_q;
        src_d = src_q;
        type_d = type_q;
        seed_d = seed_q;
        err_d = err_q;
        count_d = count_q;
        if (state_q == IDLE && start) begin
            state_d = HDR;
            beat_d = '0;
            last_d = 8'((len_c - 16'd1) >> 3);
            keep_d = len_to_last_keep(len_c);
            dst_d = dst_mac;
            src_d = src_mac;
            type_d = ethertype;
            seed_d = count_q[7:0];
            err_d = err_inject;
        end else if (hs) begin
            state_d = last_beat ? IDLE : BODY;
            beat_d = beat_q + 8'd1;
            count_d = count_q + 32'(last_beat);
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            state_q <= IDLE;
            beat_q <= '0;
            last_q <= '0;
            keep_q <= '0;
            dst_q <= '0;
            src_q <= '0;
            type_q <= '0;
            seed_q <= '0;
            err_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            beat_q <= beat_d;
            last_q <= last_d;
            keep_q <= keep_d;
            dst_q <= dst_d;
            src_q <= src_d;
            type_q <= type_d;
            seed_q <= seed_d;
            err_q <= err_d;
            count_q <= count_d;
        end
    end

    eth_frame_gen_beat u_beat (
        .beat_idx (beat_q),
        .last     (last_beat),
        .last_keep(keep_q),
        .dst_mac  (dst_q),
        .src_mac  (src_q),
        .ethertype(type_q),
        .seed     (seed_q),
        .tdata    (beat_data),
        .tkeep    (beat_keep)
    );

    assign tx_axis.tdata = valid ? beat_data : '0;
    assign tx_axis.tkeep = valid ? beat_keep : '0;
    assign tx_axis.tlast = last_beat;
    assign tx_axis.tuser = last_beat && err_q;
    assign tx_axis.tvalid = valid;
    assign busy = valid;
    assign frame_count = count_q;

`ifdef ETH_FRAME_GEN_PTP_TS_EN
    logic [TS_W-1:0] ts_q, ts_d;
    logic ts_valid_q, ts_valid_d;
    assign ts_d = tx_ptp_ts_valid ? tx_ptp_ts : ts_q;
    assign ts_valid_d = tx_ptp_ts_valid;
    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            ts_q <= '0;
            ts_valid_q <= 1'b0;
        end else begin
            ts_q <= ts_d;
            ts_valid_q <= ts_valid_d;
        end
    end
    assign ts_out = ts_q;
    assign ts_out_valid = ts_valid_q;
`else
    logic unused_ts;
    assign unused_ts = ^{tx_ptp_ts, tx_ptp_ts_valid};
    assign ts_out = '0;
    assign ts_out_valid = 1'b0;
`endif
endmodule

// File: tb/tb_eth_mac_tx_frame_gen.sv
// tb_eth_mac_tx_frame_gen: table-driven frame checks plus reset, restart and timestamp sequences.
module tb_eth_mac_tx_frame_gen;
    logic tx_clk = 1'b0;
    logic tx_rst = 1'b1;
    logic start = 1'b0;
    logic [15:0] frame_len = '0;
    logic [47:0] dst_mac = '0;
    logic [47:0] src_mac = 48'h5A5102030405;
    logic [15:0] ethertype = 16'h0800;
    logic err_inject = 1'b0;
    logic busy;
    logic [95:0] tx_ptp_ts = '0;
    logic tx_ptp_ts_valid = 1'b0;
    logic [95:0] ts_out;
    logic ts_out_valid;
    logic [31:0] frame_count;
    eth_mac_tx_frame_gen_if axis();

    eth_mac_tx_frame_gen dut (
        .tx_clk(tx_clk), .tx_rst(tx_rst), .start(start), .frame_len(frame_len),
        .dst_mac(dst_mac), .src_mac(src_mac), .ethertype(ethertype), .err_inject(err_inject),
        .busy(busy), .tx_axis(axis), .tx_ptp_ts(tx_ptp_ts), .tx_ptp_ts_valid(tx_ptp_ts_valid),
        .ts_out(ts_out), .ts_out_valid(ts_out_valid), .frame_count(frame_count)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [15:0] len;
        logic        err;
        bit          stall;
        bit          restart;
        logic [47:0] dst;
        int          exp_beats;
        logic [7:0]  exp_keep;
    } vec_t;

    vec_t vecs[6];
    int checks = 0;
    int errors = 0;
    logic [31:0] exp_count = '0;
    logic [63:0] b0, b1;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v);
        logic [111:0] hdr;
        logic [7:0] seed, ek, eb, last_keep_seen;
        logic [63:0] hd;
        logic [7:0] hk;
        logic hl, hu;
        int beats, derr, lerr, uerr, serr, cyc, p;
        bit done, held;
        hdr = {v.dst, src_mac, ethertype};
        seed = exp_count[7:0];
        beats = 0; derr = 0; lerr = 0; uerr = 0; serr = 0; cyc = 0;
        done = 0; held = 0; last_keep_seen = '0;
        hd = '0; hk = '0; hl = 0; hu = 0;
        @(negedge tx_clk);
        dst_mac = v.dst; frame_len = v.len; err_inject = v.err; start = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
        chk("tvalid_after_start", {95'd0, axis.tvalid}, 96'd1);
        while (!done && cyc < 3000) begin
            if (held && (axis.tdata !== hd || axis.tkeep !== hk || axis.tlast !== hl || axis.tuser !== hu || axis.tvalid !== 1'b1))
                serr++;
            axis.tready = v.stall ? 1'($urandom % 2) : 1'b1;
            start = v.restart && beats == 3;
            held = axis.tvalid && !axis.tready;
            hd = axis.tdata; hk = axis.tkeep; hl = axis.tlast; hu = axis.tuser;
            if (axis.tvalid && axis.tready) begin
                ek = beats == v.exp_beats - 1 ? v.exp_keep : 8'hFF;
                if (axis.tkeep !== ek) derr++;
                for (int b = 0; b < 8; b++) begin
                    p = beats * 8 + b;
                    eb = p < 14 ? hdr[111 - 8*p -: 8] : 8'(seed + 8'(p - 14));
                    if (ek[b] && axis.tdata[8*b +: 8] !== eb) derr++;
                end
                if (axis.tlast !== (beats == v.exp_beats - 1)) lerr++;
                if (axis.tuser !== (axis.tlast && v.err)) uerr++;
                if (beats == 0) b0 = axis.tdata;
                if (beats == 1) b1 = axis.tdata;
                if (axis.tlast) begin
                    done = 1;
                    last_keep_seen = axis.tkeep;
                end
                beats++;
            end
            @(negedge tx_clk);
            cyc++;
        end
        start = 1'b0;
        axis.tready = 1'b1;
        chk("frame_done", {95'd0, done}, 96'd1);
        if (done) exp_count++;
        chk("beat_count", 96'(beats), 96'(v.exp_beats));
        chk("last_tkeep", {88'd0, last_keep_seen}, {88'd0, v.exp_keep});
        chk("data_bytes_errs", 96'(derr), 96'd0);
        chk("tlast_errs", 96'(lerr), 96'd0);
        chk("tuser_errs", 96'(uerr), 96'd0);
        if (v.stall) chk("stall_hold_errs", 96'(serr), 96'd0);
        chk("idle_after_frame", {94'd0, axis.tvalid, busy}, 96'd0);
        chk("frame_count", {64'd0, frame_count}, {64'd0, exp_count});
        if (v.restart) begin
            for (int i = 0; i < 3; i++) begin
                @(negedge tx_clk);
                chk("restart_ignored", {95'd0, axis.tvalid}, 96'd0);
            end
        end
    endtask

    logic [95:0] ts_a, ts_b, exp_a, exp_b;
    logic exp_v;
    int n, cyc;

    initial begin
        vecs[0] = '{16'd60,   1'b0, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, 8,   8'h0F};
        vecs[1] = '{16'd64,   1'b0, 1'b0, 1'b0, 48'h112233445566, 8,   8'hFF};
        vecs[2] = '{16'd2000, 1'b0, 1'b0, 1'b0, 48'h0A0B0C0D0E0F, 190, 8'h03};
        vecs[3] = '{16'd10,   1'b0, 1'b0, 1'b0, 48'hFFFFFFFFFFFF, 8,   8'h0F};
        vecs[4] = '{16'd100,  1'b0, 1'b1, 1'b0, 48'hDEADBEEF0001, 13,  8'h0F};
        vecs[5] = '{16'd60,   1'b1, 1'b0, 1'b1, 48'h010203040506, 8,   8'h0F};
        axis.tready = 1'b1;
        repeat (3) @(negedge tx_clk);
        tx_rst = 1'b0;
        chk("reset_tvalid", {95'd0, axis.tvalid}, 96'd0);
        chk("reset_busy", {95'd0, busy}, 96'd0);
        chk("reset_tdata", {32'd0, axis.tdata}, 96'd0);
        chk("reset_count", {64'd0, frame_count}, 96'd0);
        chk("reset_ts_valid", {95'd0, ts_out_valid}, 96'd0);
        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i]);
            if (i == 0) begin
                chk("t1_beat0", {32'd0, b0}, {32'd0, 64'h515AFFFFFFFFFFFF});
                chk("t1_beat1", {32'd0, b1}, {32'd0, 64'h0100000805040302});
            end
        end
        // abandon a frame by resetting while beat 5 is presented
        @(negedge tx_clk);
        frame_len = 16'd100; start = 1'b1;
        @(negedge tx_clk);
        start = 1'b0;
        n = 0; cyc = 0;
        while (n < 5 && cyc < 100) begin
            if (axis.tvalid) n++;
            @(negedge tx_clk);
            cyc++;
        end
        chk("pre_reset_tvalid", {95'd0, axis.tvalid}, 96'd1);
        chk("pre_reset_count", {64'd0, frame_count}, 96'd6);
        tx_rst = 1'b1;
        @(negedge tx_clk);
        chk("midreset_tvalid", {95'd0, axis.tvalid}, 96'd0);
        chk("midreset_busy", {95'd0, busy}, 96'd0);
        chk("midreset_count", {64'd0, frame_count}, 96'd0);
        tx_rst = 1'b0;
        exp_count = '0;
        run_frame(vecs[0]);
        chk("post_reset_beat1", {32'd0, b1}, {32'd0, 64'h0100000805040302});
        // timestamp capture: single strobe then back-to-back strobes
        ts_a = 96'h000000000000000123456789;
        ts_b = 96'h00000000ABCDEF0000000042;
`ifdef ETH_FRAME_GEN_PTP_TS_EN
        exp_v = 1'b1; exp_a = ts_a; exp_b = ts_b;
`else
        exp_v = 1'b0; exp_a = '0; exp_b = '0;
`endif
        @(negedge tx_clk);
        chk("ts_idle_valid", {95'd0, ts_out_valid}, 96'd0);
        tx_ptp_ts = ts_a; tx_ptp_ts_valid = 1'b1;
        @(negedge tx_clk);
        tx_ptp_ts_valid = 1'b0; tx_ptp_ts = '1;
        chk("ts_single_valid", {95'd0, ts_out_valid}, {95'd0, exp_v});
        chk("ts_single_value", ts_out, exp_a);
        @(negedge tx_clk);
        chk("ts_single_pulse_end", {95'd0, ts_out_valid}, 96'd0);
        tx_ptp_ts = ts_a; tx_ptp_ts_valid = 1'b1;
        @(negedge tx_clk);
        tx_ptp_ts = ts_b;
        chk("ts_b2b_first_valid", {95'd0, ts_out_valid}, {95'd0, exp_v});
        chk("ts_b2b_first_value", ts_out, exp_a);
        @(negedge tx_clk);
        tx_ptp_ts_valid = 1'b0;
        chk("ts_b2b_second_valid", {95'd0, ts_out_valid}, {95'd0, exp_v});
        chk("ts_b2b_second_value", ts_out, exp_b);
        @(negedge tx_clk);
        chk("ts_b2b_end", {95'd0, ts_out_valid}, 96'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eth_mac_tx_frame_gen.md
Name: eth_mac_tx_frame_gen

Overview:
- Transmit-side frame source that drives the 64-bit AXI-stream TX interface of an Ethernet MAC.
- Builds one frame per start pulse: header, then an incrementing payload pattern, padded/clamped to legal length.
- Honours tready backpressure, counts sent frames, and returns MAC TX PTP timestamps to the user.
- Sits between test/control logic and the MAC TX port in the MAC loopback/verification designs.

Parameters:
MIN_LEN, 60, minimum frame length in bytes excluding FCS; shorter requests are padded.
MAX_LEN, 1514, maximum frame length in bytes excluding FCS; longer requests are clamped.
TS_W, 96, PTP timestamp width.

Ports:
tx_clk  in  1  clock
tx_rst  in  1  reset, synchronous, active-high
start  in  1  single-cycle request; sampled only in IDLE
frame_len  in  16  requested length in bytes, excl. FCS
dst_mac  in  48  destination MAC; [47:40] is wire byte 0
src_mac  in  48  source MAC; [47:40] is wire byte 6
ethertype  in  16  [15:8] is wire byte 12
err_inject  in  1  mark frame bad via tuser on last beat
busy  out  1  frame in progress
tx_axis_tdata  out  64  byte n of beat in [8n+7:8n]
tx_axis_tkeep  out  8  byte enables
tx_axis_tlast  out  1  last beat
tx_axis_tuser  out  1  error flag
tx_axis_tvalid  out  1  beat valid
tx_axis_tready  in  1  MAC accepts beat
tx_ptp_ts  in  TS_W  TX timestamp from MAC
tx_ptp_ts_valid  in  1  timestamp strobe
ts_out  out  TS_W  captured timestamp
ts_out_valid  out  1  one-cycle strobe
frame_count  out  32  frames completed, wraps

Behaviour:
- Single clock tx_clk; tx_rst synchronous active-high. All outputs reset to 0; FSM to IDLE.
- FSM states and transitions:
  - IDLE: on start, latch all inputs, compute L = clamp(frame_len, MIN_LEN, MAX_LEN), go to HDR. tvalid=1 and busy=1 from the next cycle.
  - HDR: beat 0 = dst bytes 0-5, src bytes 6-7. Advance to BODY on handshake.
  - BODY: beats 1..ceil(L/8)-1. Beat 1 = src bytes 8-11, ethertype bytes 12-13, payload bytes 14-15. Advance on each handshake.
  - After the last handshake: return to IDLE; busy=0 and tvalid=0 the next cycle.
- Payload pattern: payload byte k (wire byte 14+k) = (frame_count[7:0] + k) mod 256, using frame_count latched at start. Padding bytes continue the pattern.
- tkeep: 0xFF on all non-last beats. Last beat = 0xFF if L%8==0, else (1<<(L%8))-1.
- tlast is asserted on beat ceil(L/8)-1 only.
- tuser = latched err_inject on the last beat; 0 on all other beats.
- Handshake: a beat transfers when tvalid&&tready. While tvalid=1 and tready=0, tdata/tkeep/tlast/tuser hold stable.
  - No bubbles inside a frame: the next beat is presented the cycle after each handshake.
  - At least one idle cycle between frames.
- start while busy is ignored; it is not queued.
- frame_count increments on the last-beat handshake; 0xFFFFFFFF wraps to 0.
- Reset asserted mid-frame: tvalid drops the next cycle, frame is abandoned, frame_count is cleared.

Optional Feature:
- Macro ETH_FRAME_GEN_PTP_TS_EN.
- Defined:
  - On tx_ptp_ts_valid, ts_out <= tx_ptp_ts and ts_out_valid pulses for one cycle (one-cycle latency).
  - Capture is independent of FSM state; back-to-back strobes give back-to-back pulses.
- Undefined: ts_out and ts_out_valid are tied to 0; tx_ptp_ts inputs are unused.

Decomposition:
- Package eth_frame_gen_pkg:
  - constants ETH_HDR_LEN=14, BEAT_BYTES=8, KEEP_W=8
  - state enum {IDLE, HDR, BODY}
  - function len_to_last_keep
- Sub-module eth_frame_gen_beat: combinational beat-data assembler (beat index, latched header, pattern seed → tdata/tkeep).

Test Plan:
1. frame_len=60, dst=FFFFFFFFFFFF, src=5A5102030405, ethertype=0800, tready=1 → 8 beats; beat0 tdata=0x515AFFFFFFFFFFFF; beat1 tdata=0x0100_0008_0504_0302; last tkeep=0x0F; frame_count=1.
2. frame_len=64, then frame_len=2000 → 8 beats with last tkeep=0xFF; then 190 beats (1514 B) with last tkeep=0x03.
3. frame_len=10 → padded to 60, 8 beats; payload bytes 14..59 = seed..seed+45 mod 256.
4. tready random 50% during a 100-byte frame → beats unchanged while stalled; 13 beats total, last tkeep=0x0F. Then assert tx_rst at beat 5 → tvalid=0 next cycle, frame_count=0.
5. err_inject=1, frame_len=60; then start pulsed while busy → tuser=1 on beat 7 only; second start ignored; frame_count increments by 1.
6. tx_ptp_ts_valid pulse with ts=0x000000000000000123456789 → with macro: ts_out equals value and ts_out_valid high exactly 1 cycle later; without macro: both stay 0.
